// File: rtl/hack_kbd_ctrl.sv
// hack_kbd_ctrl: PS/2 (scan-code set 2) receiver feeding the Hack KBD register.
// Frames are deserialized on synchronized PS/2 clock falls. Make/break and E0
// prefixes are tracked, and mapped keys are translated to Hack character codes.
module hack_kbd_ctrl #(
    parameter int TIMEOUT_CYCLES = 50000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        ps2_clk,
    input  logic        ps2_data,
    output logic [15:0] out,
    output logic        key_valid,
    output logic        frame_err
);

    localparam int TW = ($clog2(TIMEOUT_CYCLES + 1) > 16) ? $clog2(TIMEOUT_CYCLES + 1) : 16;

    typedef enum logic [1:0] {S_IDLE, S_DATA, S_PARITY, S_STOP} state_t;

    // Synchronizers idle high (the PS/2 bus idle level), so leaving reset never fakes an edge.
    logic ps2_clk_s1_q, ps2_clk_s2_q, ps2_clk_prev_q;
    logic ps2_dat_s1_q, ps2_dat_s2_q;

    state_t         state_q, state_d;
    logic [2:0]     bit_cnt_q, bit_cnt_d;
    logic [7:0]     shreg_q, shreg_d;
    logic           par_q, par_d;
    logic [TW-1:0]  tmo_q, tmo_d;
    logic           ext_q, ext_d;
    logic           brk_q, brk_d;
    logic [15:0]    out_q, out_d;
    logic           key_valid_q, key_valid_d;
    logic           frame_err_q, frame_err_d;

    logic           fall;
    logic [15:0]    code;

    assign out       = out_q;
    assign key_valid = key_valid_q;
    assign frame_err = frame_err_q;

    // Set 2 scan code to Hack code; 0 means the key is not mapped.
    function automatic logic [15:0] xlate(input logic [7:0] sc, input logic e);
        logic [15:0] r;
        r = 16'd0;
        if (e) begin
            case (sc)
                8'h6B:   r = 16'd130;
                8'h75:   r = 16'd131;
                8'h74:   r = 16'd132;
                8'h72:   r = 16'd133;
                default: r = 16'd0;
            endcase
        end else begin
            case (sc)
                8'h1C: r = 16'd65;  8'h32: r = 16'd66;  8'h21: r = 16'd67;  8'h23: r = 16'd68;
                8'h24: r = 16'd69;  8'h2B: r = 16'd70;  8'h34: r = 16'd71;  8'h33: r = 16'd72;
                8'h43: r = 16'd73;  8'h3B: r = 16'd74;  8'h42: r = 16'd75;  8'h4B: r = 16'd76;
                8'h3A: r = 16'd77;  8'h31: r = 16'd78;  8'h44: r = 16'd79;  8'h4D: r = 16'd80;
                8'h15: r = 16'd81;  8'h2D: r = 16'd82;  8'h1B: r = 16'd83;  8'h2C: r = 16'd84;
                8'h3C: r = 16'd85;  8'h2A: r = 16'd86;  8'h1D: r = 16'd87;  8'h22: r = 16'd88;
                8'h35: r = 16'd89;  8'h1A: r = 16'd90;
                8'h45: r = 16'd48;  8'h16: r = 16'd49;  8'h1E: r = 16'd50;  8'h26: r = 16'd51;
                8'h25: r = 16'd52;  8'h2E: r = 16'd53;  8'h36: r = 16'd54;  8'h3D: r = 16'd55;
                8'h3E: r = 16'd56;  8'h46: r = 16'd57;
                8'h29: r = 16'd32;  8'h5A: r = 16'd128; 8'h66: r = 16'd129; 8'h76: r = 16'd140;
                default: r = 16'd0;
            endcase
        end
        return r;
    endfunction

    // 2-FF synchronizers plus a delayed copy of ps2_clk for fall detection.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ps2_clk_s1_q   <= 1'b1;
            ps2_clk_s2_q   <= 1'b1;
            ps2_clk_prev_q <= 1'b1;
            ps2_dat_s1_q   <= 1'b1;
            ps2_dat_s2_q   <= 1'b1;
        end else begin
            ps2_clk_s1_q   <= ps2_clk;
            ps2_clk_s2_q   <= ps2_clk_s1_q;
            ps2_clk_prev_q <= ps2_clk_s2_q;
            ps2_dat_s1_q   <= ps2_data;
            ps2_dat_s2_q   <= ps2_dat_s1_q;
        end
    end

    assign fall = ps2_clk_prev_q & ~ps2_clk_s2_q;
    assign code = xlate(shreg_q, ext_q);

    // Frame FSM, timeout, prefix tracking and key translation.
    always_comb begin
        state_d     = state_q;
        bit_cnt_d   = bit_cnt_q;
        shreg_d     = shreg_q;
        par_d       = par_q;
        tmo_d       = tmo_q;
        ext_d       = ext_q;
        brk_d       = brk_q;
        out_d       = out_q;
        key_valid_d = 1'b0;
        frame_err_d = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (fall && !ps2_dat_s2_q) begin
                    state_d   = S_DATA;
                    bit_cnt_d = 3'd0;
                end
            end
            S_DATA: begin
                if (fall) begin
                    shreg_d   = {ps2_dat_s2_q, shreg_q[7:1]};
                    bit_cnt_d = bit_cnt_q + 3'd1;
                    if (bit_cnt_q == 3'd7) state_d = S_PARITY;
                end
            end
            S_PARITY: begin
                if (fall) begin
                    par_d   = ps2_dat_s2_q;
                    state_d = S_STOP;
                end
            end
            S_STOP: begin
                if (fall) begin
                    state_d = S_IDLE;
                    if (ps2_dat_s2_q && (^{shreg_q, par_q})) begin
                        if (shreg_q == 8'hE0) begin
                            ext_d = 1'b1;
                        end else if (shreg_q == 8'hF0) begin
                            brk_d = 1'b1;
                        end else begin
                            ext_d = 1'b0;
                            brk_d = 1'b0;
                            if (code != 16'd0) begin
                                if (!brk_q) begin
                                    out_d       = code;
                                    key_valid_d = 1'b1;
                                end else if (code == out_q) begin
                                    out_d       = 16'd0;
                                    key_valid_d = 1'b1;
                                end
                            end
                        end
                    end else begin
                        frame_err_d = 1'b1;
                        ext_d       = 1'b0;
                        brk_d       = 1'b0;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase

        // Mid-frame watchdog; a falling edge in the same cycle keeps the frame alive.
        if (state_q == S_IDLE) begin
            tmo_d = '0;
        end else if (fall) begin
            tmo_d = '0;
        end else if (tmo_q == TW'(TIMEOUT_CYCLES - 1)) begin
            tmo_d       = '0;
            state_d     = S_IDLE;
            frame_err_d = 1'b1;
            ext_d       = 1'b0;
            brk_d       = 1'b0;
        end else begin
            tmo_d = tmo_q + TW'(1);
        end
    end

    // State and registered outputs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= S_IDLE;
            bit_cnt_q   <= 3'd0;
            shreg_q     <= 8'd0;
            par_q       <= 1'b0;
            tmo_q       <= '0;
            ext_q       <= 1'b0;
            brk_q       <= 1'b0;
            out_q       <= 16'd0;
            key_valid_q <= 1'b0;
            frame_err_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            bit_cnt_q   <= bit_cnt_d;
            shreg_q     <= shreg_d;
            par_q       <= par_d;
            tmo_q       <= tmo_d;
            ext_q       <= ext_d;
            brk_q       <= brk_d;
            out_q       <= out_d;
            key_valid_q <= key_valid_d;
            frame_err_q <= frame_err_d;
        end
    end

endmodule

// File: tb/tb_hack_kbd_ctrl.sv
// Directed bench for hack_kbd_ctrl: bit-bangs PS/2 frames and checks out,
// key_valid / frame_err pulse counts and decode latency.
module tb_hack_kbd_ctrl;

    localparam int TMO  = 200;
    localparam int HALF = 8;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        ps2_clk = 1'b1;
    logic        ps2_data = 1'b1;
    logic [15:0] out;
    logic        key_valid;
    logic        frame_err;

    int vecs = 0, errs = 0;
    int kv_cnt = 0, fe_cnt = 0, kv_exp = 0, fe_exp = 0;
    int cyc = 0, fall_cyc = 0, kv_cyc = 0;

    hack_kbd_ctrl #(.TIMEOUT_CYCLES(TMO)) dut (
        .clk(clk), .reset(reset), .ps2_clk(ps2_clk), .ps2_data(ps2_data),
        .out(out), .key_valid(key_valid), .frame_err(frame_err)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input int obs, input int exp);
        vecs++;
        assert (obs === exp) else begin
            errs++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Pulse bookkeeping; the two strobes must never coincide.
    always @(negedge clk) begin
        if (!reset) begin
            if (key_valid) begin kv_cnt++; kv_cyc = cyc; end
            if (frame_err) fe_cnt++;
            if (key_valid || frame_err) chk("kv_fe_exclusive", int'(key_valid & frame_err), 0);
        end
    end

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic ps2_bit(input logic b);
        @(negedge clk);
        ps2_data = b;
        idle(HALF);
        ps2_clk  = 1'b0;
        fall_cyc = cyc;
        idle(HALF);
        ps2_clk  = 1'b1;
    endtask

    task automatic send_frame(input logic [7:0] b, input logic bad_par, input logic stop);
        ps2_bit(1'b0);
        for (int i = 0; i < 8; i++) ps2_bit(b[i]);
        ps2_bit((~^b) ^ bad_par);
        ps2_bit(stop);
        ps2_data = 1'b1;
        idle(6);
    endtask

    task automatic send_partial(input logic [7:0] b, input int n);
        ps2_bit(1'b0);
        for (int i = 0; i < n; i++) ps2_bit(b[i]);
        ps2_data = 1'b1;
    endtask

    task automatic expect_now(input string tag, input int o);
        chk({tag, "/out"}, int'(out), o);
        chk({tag, "/kv_count"}, kv_cnt, kv_exp);
        chk({tag, "/fe_count"}, fe_cnt, fe_exp);
    endtask

    // Good frame, then check out and pulse counts.
    task automatic step(input string tag, input logic [7:0] b, input int o, input int dkv);
        send_frame(b, 1'b0, 1'b1);
        kv_exp += dkv;
        expect_now(tag, o);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset values
        idle(3);
        chk("rst/out", int'(out), 0);
        chk("rst/key_valid", int'(key_valid), 0);
        chk("rst/frame_err", int'(frame_err), 0);
        reset = 1'b0;
        idle(3);

        // Reset mid-frame after 4 data bits
        send_partial(8'h1C, 4);
        @(negedge clk);
        reset = 1'b1;
        idle(3);
        chk("midrst/out", int'(out), 0);
        reset = 1'b0;
        idle(4);
        step("post_rst_A", 8'h1C, 65, 1);
        chk("latency_stop_to_kv", kv_cyc - fall_cyc, 3);

        // Make/break A (with typematic repeat first)
        step("A_repeat", 8'h1C, 65, 1);
        step("A_F0", 8'hF0, 65, 0);
        step("A_break", 8'h1C, 0, 1);

        // Overlapping keys
        step("ov_A", 8'h1C, 65, 1);
        step("ov_B", 8'h32, 66, 1);
        step("ov_F0a", 8'hF0, 66, 0);
        step("ov_brkA", 8'h1C, 66, 0);
        step("ov_F0b", 8'hF0, 66, 0);
        step("ov_brkB", 8'h32, 0, 1);

        // Extended arrow up
        step("up_E0", 8'hE0, 0, 0);
        step("up_make", 8'h75, 131, 1);
        step("up_E0b", 8'hE0, 131, 0);
        step("up_F0", 8'hF0, 131, 0);
        step("up_break", 8'h75, 0, 1);

        // Parity / stop errors, flag clearing by bad frame
        step("err_A", 8'h1C, 65, 1);
        send_frame(8'h1C, 1'b1, 1'b1); fe_exp++;
        expect_now("bad_parity", 65);
        send_frame(8'h1C, 1'b0, 1'b0); fe_exp++;
        expect_now("bad_stop", 65);
        step("err_F0", 8'hF0, 65, 0);
        send_frame(8'h1C, 1'b1, 1'b1); fe_exp++;
        expect_now("bad_after_F0", 65);
        step("make_after_bad", 8'h1C, 65, 1);

        // Timeout after 3 data bits
        send_partial(8'h29, 3);
        idle(TMO - 40);
        expect_now("tmo_early", 65);
        idle(80);
        fe_exp++;
        expect_now("tmo_fired", 65);
        step("space", 8'h29, 32, 1);

        // Unmapped keys, plain and extended
        step("unmapped_0E", 8'h0E, 32, 0);
        step("ext_E0", 8'hE0, 32, 0);
        step("ext_unmapped_1C", 8'h1C, 32, 0);
        step("space_F0", 8'hF0, 32, 0);
        step("space_break", 8'h29, 0, 1);

        // Table spot checks
        step("digit0", 8'h45, 48, 1);
        step("digit9", 8'h46, 57, 1);
        step("enter", 8'h5A, 128, 1);
        step("esc", 8'h76, 140, 1);
        step("left_E0", 8'hE0, 140, 0);
        step("left", 8'h6B, 130, 1);

        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

endmodule
